mem_req_arbiter: RTL



---
 rtl/mem_req_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin, request-locking merge of instr/data req-gnt ports onto one memory port.
// Optional build macro MEM_ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module mem_req_arbiter #(
  parameter int unsigned AddrSize = 32,
  parameter int unsigned DataSize = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_mem_req,
  output logic                      instr_mem_gnt,
  input  logic [AddrSize-1:0]       instr_mem_addr,
  input  logic [DataSize-1:0]       instr_mem_wdata,
  input  logic [DataSize/8-1:0]     instr_mem_strb,
  input  logic                      instr_mem_we,
  output logic [DataSize-1:0]       instr_mem_rdata,
  input  logic                      data_mem_req,
  output logic                      data_mem_gnt,
  input  logic [AddrSize-1:0]       data_mem_addr,
  input  logic [DataSize-1:0]       data_mem_wdata,
  input  logic [DataSize/8-1:0]     data_mem_strb,
  input  logic                      data_mem_we,
  output logic [DataSize-1:0]       data_mem_rdata,
  output logic                      mem_req,
  input  logic                      mem_gnt,
  output logic [AddrSize-1:0]       mem_addr,
  output logic [DataSize-1:0]       mem_wdata,
  output logic [DataSize/8-1:0]     mem_strb,
  output logic                      mem_we,
  input  logic [DataSize-1:0]       mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]               perf_instr_grants_o,
  output logic [31:0]               perf_data_grants_o,
  output logic [31:0]               perf_conflicts_o
`endif
);

  typedef enum logic {MST_INSTR = 1'b0, MST_DATA = 1'b1} master_e;

  master_e             prio_q, prio_d;
  logic                lock_q, lock_d;
  master_e             lock_owner_q, lock_owner_d;
  logic                rsp_valid_q, rsp_valid_d;
  master_e             rsp_owner_q, rsp_owner_d;
  logic [DataSize-1:0] instr_hold_q, instr_hold_d;
  logic [DataSize-1:0] data_hold_q, data_hold_d;

  master_e sel;
  logic    accept;
  logic    instr_rsp;
  logic    data_rsp;

  // A stalled request keeps ownership; otherwise the lone or prioritised requester wins.
  always_comb begin
    sel = MST_INSTR;
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (data_mem_req && (!instr_mem_req || prio_q == MST_DATA)) begin
      sel = MST_DATA;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_strb  = '0;
    mem_we    = 1'b0;
    if (sel == MST_DATA) begin
      if (data_mem_req) begin
        mem_req   = 1'b1;
        mem_addr  = data_mem_addr;
        mem_wdata = data_mem_wdata;
        mem_strb  = data_mem_strb;
        mem_we    = data_mem_we;
      end
    end else if (instr_mem_req) begin
      mem_req   = 1'b1;
      mem_addr  = instr_mem_addr;
      mem_wdata = instr_mem_wdata;
      mem_strb  = instr_mem_strb;
      mem_we    = instr_mem_we;
    end
  end

  assign accept        = mem_req && mem_gnt;
  assign instr_mem_gnt = accept && (sel == MST_INSTR);
  assign data_mem_gnt  = accept && (sel == MST_DATA);

  assign instr_rsp       = rsp_valid_q && (rsp_owner_q == MST_INSTR);
  assign data_rsp        = rsp_valid_q && (rsp_owner_q == MST_DATA);
  assign instr_mem_rdata = instr_rsp ? mem_rdata : instr_hold_q;
  assign data_mem_rdata  = data_rsp  ? mem_rdata : data_hold_q;

  always_comb begin
    prio_d       = prio_q;
    lock_d       = mem_req && !mem_gnt;
    lock_owner_d = lock_owner_q;
    rsp_valid_d  = accept;
    rsp_owner_d  = rsp_owner_q;
    instr_hold_d = instr_hold_q;
    data_hold_d  = data_hold_q;
    if (lock_d) begin
      lock_owner_d = sel;
    end
    if (accept) begin
      prio_d      = (sel == MST_INSTR) ? MST_DATA : MST_INSTR;
      rsp_owner_d = sel;
    end
    if (instr_rsp) begin
      instr_hold_d = mem_rdata;
    end
    if (data_rsp) begin
      data_hold_d = mem_rdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q       <= MST_INSTR;
      lock_q       <= 1'b0;
      lock_owner_q <= MST_INSTR;
      rsp_valid_q  <= 1'b0;
      rsp_owner_q  <= MST_INSTR;
      instr_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      prio_q       <= prio_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_owner_q  <= rsp_owner_d;
      instr_hold_q <= instr_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [31:0] perf_data_q, perf_data_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_data_d  = perf_data_q;
    perf_conf_d  = perf_conf_q;
    if (instr_mem_gnt && perf_instr_q != '1) begin
      perf_instr_d = perf_instr_q + 32'd1;
    end
    if (data_mem_gnt && perf_data_q != '1) begin
      perf_data_d = perf_data_q + 32'd1;
    end
    if (instr_mem_req && data_mem_req && !lock_q && perf_conf_q != '1) begin
      perf_conf_d = perf_conf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_instr_q <= '0;
      perf_data_q  <= '0;
      perf_conf_q  <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_data_q  <= perf_data_d;
      perf_conf_q  <= perf_conf_d;
    end
  end

  assign perf_instr_grants_o = perf_instr_q;
  assign perf_data_grants_o  = perf_data_q;
  assign perf_conflicts_o    = perf_conf_q;
`endif

endmodule
